// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the CPU memory subsystem.
//   word_t      : 32-bit machine word
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : memory arbiter grant state
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the fetch request, data request and RAM port signals that pass
// through the memory arbiter.
//   master : requesters and RAM model (drive requests, RAM status/read data)
//   slave  : the arbiter (drives stalls, returned words, RAM enables/address)
// -----------------------------------------------------------------------------
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // fetch side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // data side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // sticky error flag
  logic      mem_err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/arb_counter.sv
// -----------------------------------------------------------------------------
// arb_counter
// Up-counter used by the memory arbiter for its starvation and timeout counts.
//   clk, n_rst  : clock, asynchronous active-low reset
//   clear       : synchronous clear (wins over enable)
//   enable      : count up by one this cycle
//   match_value : terminal value to compare against
//   at_match    : high while the count equals match_value
// With SATURATE set the count holds at all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module arb_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] match_value,
  output logic             at_match
);

  logic [WIDTH-1:0] count;
  logic             at_max;

  assign at_max   = (count == {WIDTH{1'b1}});
  assign at_match = (count == match_value);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !(SATURATE && at_max)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one RAM port between instruction fetch and data access.
// Data wins arbitration unless fetch has watched STARVE_LIMIT consecutive data
// completions, in which case fetch is forced through. A grant that sees no
// ACCESS/ERROR within TIMEOUT cycles is aborted and flagged in mem_err.
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : slave side of memory_arbiter_if (fetch, data and RAM signals)
// Parameters:
//   STARVE_LIMIT (0..15, 0 = pure data priority)
//   TIMEOUT      (2..255 cycles per grant)
// -----------------------------------------------------------------------------
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic             clk,
  input logic             n_rst,
  memory_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MATCH = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam bit         STARVE_ON    = (STARVE_LIMIT != 0);

  arb_state_t state, next_state;

  logic  dreq;
  logic  ram_done;
  logic  starve_at_limit;
  logic  starve_force;
  logic  timeout_hit;
  logic  icomplete, dcomplete;
  logic  starve_clear, starve_inc;
  logic  set_err;
  logic  mem_err_q;
  logic  ram_ren, ram_wen;
  word_t ram_addr, ram_store, iload, dload;

  assign dreq         = bus.dREN | bus.dWEN;
  assign ram_done     = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
  assign starve_force = bus.iREN && STARVE_ON && starve_at_limit;

  // State register; reset drops straight back to IDLE so the RAM enables,
  // which decode from state, fall asynchronously with n_rst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. A withdrawn request ends the grant with no
  // completion; otherwise ACCESS/ERROR completes it, and the timeout aborts
  // it while the requester keeps waiting so it re-arbitrates from IDLE.
  always_comb begin
    next_state   = state;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;
    iload        = '0;
    dload        = '0;
    icomplete    = 1'b0;
    dcomplete    = 1'b0;
    starve_clear = 1'b0;
    starve_inc   = 1'b0;
    set_err      = 1'b0;

    case (state)
      IDLE: begin
        if (dreq && !starve_force) begin
          next_state = DGRANT;
        end else if (bus.iREN) begin
          next_state = IGRANT;
        end
      end

      IGRANT: begin
        ram_ren  = bus.iREN;
        ram_addr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (ram_done) begin
          icomplete    = 1'b1;
          iload        = bus.ramload;
          starve_clear = 1'b1;
          set_err      = (bus.ramstate == ERROR);
          next_state   = IDLE;
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end
      end

      DGRANT: begin
        ram_wen   = bus.dWEN;
        ram_ren   = bus.dREN && !bus.dWEN;
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (!dreq) begin
          next_state = IDLE;
        end else if (ram_done) begin
          dcomplete    = 1'b1;
          dload        = bus.dWEN ? '0 : bus.ramload;
          starve_inc   = bus.iREN;
          starve_clear = !bus.iREN;
          set_err      = (bus.ramstate == ERROR);
          next_state   = IDLE;
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_err_q <= 1'b0;
    end else if (set_err) begin
      mem_err_q <= 1'b1;
    end
  end

  // Counts data completions that happened while fetch was waiting.
  arb_counter #(.WIDTH(4), .SATURATE(1'b1)) u_starve (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (starve_clear),
    .enable      (starve_inc),
    .match_value (STARVE_MATCH),
    .at_match    (starve_at_limit)
  );

  // Cycles spent in the current grant; cleared whenever the grant ends.
  arb_counter #(.WIDTH(8), .SATURATE(1'b1)) u_timeout (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (next_state == IDLE),
    .enable      (state != IDLE),
    .match_value (TIMEOUT_LAST),
    .at_match    (timeout_hit)
  );

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.iwait    = bus.iREN && !icomplete;
  assign bus.dwait    = dreq && !dcomplete;
  assign bus.mem_err  = mem_err_q;

  // Simultaneous read and write is a requester bug; the write is served.
  rw_exclusive: assert property (@(posedge clk) disable iff (!n_rst)
                                 !(bus.dREN && bus.dWEN))
    else $error("memory_arbiter: dREN and dWEN high together, write served");

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed scenarios followed by randomized requester/RAM traffic, all
// compared cycle by cycle against a transaction-level model of who owns the
// RAM port, how long the grant has lasted and how often fetch has lost out.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_LIMIT = 2;
  localparam int TIMEOUT      = 4;
  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int DATA  = 2;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: current owner, grant length so far, fetch losses, error.
  int    owner, age, starve;
  logic  err;
  word_t gaddr, gstore;
  int    n_owner, n_age, n_starve;
  logic  n_err;
  word_t n_gaddr, n_gstore;
  logic  last_icomp, last_dcomp;

  // Expected outputs for the current cycle.
  logic  e_ren, e_wen, e_iwait, e_dwait;
  word_t e_addr, e_store, e_iload, e_dload;
  bit    chk_store, chk_iload, chk_dload;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner = NONE; age = 0; starve = 0; err = 1'b0; gaddr = '0; gstore = '0;
    n_owner = NONE; n_age = 0; n_starve = 0; n_err = 1'b0; n_gaddr = '0; n_gstore = '0;
    last_icomp = 1'b0; last_dcomp = 1'b0;
  endtask

  // Work out this cycle's outputs and the model's state after the edge.
  task automatic modelEval();
    logic dreq, done, forced;
    dreq = bus.dREN || bus.dWEN;
    done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_iwait = bus.iREN; e_dwait = dreq;
    chk_store = 1'b1; chk_iload = 1'b1; chk_dload = 1'b1;
    n_owner = NONE; n_age = 0; n_starve = starve; n_err = err;
    n_gaddr = gaddr; n_gstore = gstore;
    last_icomp = 1'b0; last_dcomp = 1'b0;
    if (owner == NONE) begin
      forced = bus.iREN && (STARVE_LIMIT != 0) && (starve == STARVE_LIMIT);
      if (dreq && !forced) begin
        n_owner = DATA; n_gaddr = bus.daddr; n_gstore = bus.dstore;
      end else if (bus.iREN) begin
        n_owner = FETCH; n_gaddr = bus.iaddr;
      end
    end else if (owner == FETCH) begin
      e_ren = bus.iREN; e_addr = gaddr;
      chk_store = 1'b0; chk_iload = 1'b0; chk_dload = 1'b0;
      if (bus.iREN && done) begin
        e_iwait = 1'b0; chk_iload = 1'b1; e_iload = bus.ramload;
        last_icomp = 1'b1; n_starve = 0;
        if (bus.ramstate == ERROR) n_err = 1'b1;
      end else if (bus.iREN && age == TIMEOUT - 1) begin
        n_err = 1'b1;
      end else if (bus.iREN) begin
        n_owner = FETCH; n_age = age + 1;
      end
    end else begin
      e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN; e_addr = gaddr; e_store = gstore;
      chk_iload = 1'b0; chk_dload = 1'b0;
      if (dreq && done) begin
        e_dwait = 1'b0; chk_dload = 1'b1; e_dload = bus.dWEN ? 32'h0 : bus.ramload;
        last_dcomp = 1'b1;
        n_starve = bus.iREN ? ((starve < 15) ? starve + 1 : 15) : 0;
        if (bus.ramstate == ERROR) n_err = 1'b1;
      end else if (dreq && age == TIMEOUT - 1) begin
        n_err = 1'b1;
      end else if (dreq) begin
        n_owner = DATA; n_age = age + 1;
      end
    end
  endtask

  task automatic evalAndCheck();
    modelEval();
    checkOutput("ramREN",  32'(bus.ramREN),  32'(e_ren));
    checkOutput("ramWEN",  32'(bus.ramWEN),  32'(e_wen));
    checkOutput("ramaddr", bus.ramaddr,      e_addr);
    checkOutput("iwait",   32'(bus.iwait),   32'(e_iwait));
    checkOutput("dwait",   32'(bus.dwait),   32'(e_dwait));
    checkOutput("mem_err", 32'(bus.mem_err), 32'(err));
    if (chk_store) checkOutput("ramstore", bus.ramstore, e_store);
    if (chk_iload) checkOutput("iload",    bus.iload,    e_iload);
    if (chk_dload) checkOutput("dload",    bus.dload,    e_dload);
  endtask

  task automatic sample();
    @(negedge clk);
    evalAndCheck();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    owner = n_owner; age = n_age; starve = n_starve; err = n_err;
    gaddr = n_gaddr; gstore = n_gstore;
  endtask

  task automatic dropAll();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
  endtask

  // Random requesters that hold until served, plus a random RAM status.
  task automatic applyStimulus();
    int r;
    if (bus.iREN) begin
      if (last_icomp || $urandom_range(0, 39) == 0) bus.iREN = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.iREN  = 1'b1;
      bus.iaddr = $urandom() & 32'hFFFF_FFFC;
    end
    if (bus.dREN || bus.dWEN) begin
      if (last_dcomp || $urandom_range(0, 39) == 0) begin
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 0) bus.dREN = 1'b1;
      else                           bus.dWEN = 1'b1;
      bus.daddr  = $urandom() & 32'hFFFF_FFFC;
      bus.dstore = $urandom();
    end
    r = $urandom_range(0, 19);
    bus.ramstate = (r == 0) ? ERROR : (r < 8) ? ACCESS : (r < 14) ? BUSY : FREE;
    bus.ramload  = $urandom();
  endtask

  initial begin
    int dcount;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    modelReset();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ramREN",   32'(bus.ramREN),  32'd0);
    checkOutput("rst_ramWEN",   32'(bus.ramWEN),  32'd0);
    checkOutput("rst_ramaddr",  bus.ramaddr,      32'd0);
    checkOutput("rst_ramstore", bus.ramstore,     32'd0);
    checkOutput("rst_iload",    bus.iload,        32'd0);
    checkOutput("rst_dload",    bus.dload,        32'd0);
    checkOutput("rst_mem_err",  32'(bus.mem_err), 32'd0);
    n_rst = 1'b1;
    advance();

    // Fetch only: two-cycle minimum latency
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040; bus.ramstate = FREE;
    sample(); checkOutput("t1_c0_ramREN", 32'(bus.ramREN), 32'd0); advance();
    bus.ramstate = BUSY;
    sample();
    checkOutput("t1_c1_ramREN",  32'(bus.ramREN), 32'd1);
    checkOutput("t1_c1_ramaddr", bus.ramaddr, 32'h40);
    advance();
    bus.ramstate = ACCESS; bus.ramload = 32'h2401_0005;
    sample();
    checkOutput("t1_c2_iwait", 32'(bus.iwait), 32'd0);
    checkOutput("t1_c2_iload", bus.iload, 32'h2401_0005);
    advance();
    bus.ramstate = FREE;
    sample();
    checkOutput("t1_c3_idle_ramREN", 32'(bus.ramREN), 32'd0);
    checkOutput("t1_c3_iwait", 32'(bus.iwait), 32'd1);
    advance();
    bus.iREN = 1'b0;
    sample(); checkOutput("t1_withdraw_ramREN", 32'(bus.ramREN), 32'd0); advance();
    sample(); advance();

    // Fetch and data together: data first, then fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = BUSY;
    sample(); checkOutput("t2_c0_dwait", 32'(bus.dwait), 32'd1); advance();
    bus.ramstate = ACCESS; bus.ramload = 32'h1111_2222;
    sample();
    checkOutput("t2_c1_ramaddr", bus.ramaddr, 32'h100);
    checkOutput("t2_c1_dload",   bus.dload, 32'h1111_2222);
    checkOutput("t2_c1_dwait",   32'(bus.dwait), 32'd0);
    checkOutput("t2_c1_iwait",   32'(bus.iwait), 32'd1);
    advance();
    bus.dREN = 1'b0;
    sample(); advance();
    bus.ramload = 32'h3333_4444;
    sample();
    checkOutput("t2_c3_ramaddr", bus.ramaddr, 32'h80);
    checkOutput("t2_c3_iload",   bus.iload, 32'h3333_4444);
    checkOutput("t2_c3_iwait",   32'(bus.iwait), 32'd0);
    advance();
    dropAll();
    sample(); advance();

    // Starvation override after STARVE_LIMIT data completions
    bus.iREN = 1'b1; bus.iaddr = 32'hC0; bus.dREN = 1'b1; bus.daddr = 32'h140;
    bus.ramstate = ACCESS; bus.ramload = 32'h55;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i <= 4 && bus.dwait == 1'b0) dcount++;
      if (i == 5) begin
        checkOutput("t3_forced_ramaddr", bus.ramaddr, 32'hC0);
        checkOutput("t3_forced_iwait",   32'(bus.iwait), 32'd0);
      end
      if (i == 7) begin
        checkOutput("t3_after_ramaddr", bus.ramaddr, 32'h140);
        checkOutput("t3_after_dwait",   32'(bus.dwait), 32'd0);
      end
      advance();
    end
    checkOutput("t3_data_wins", 32'(dcount), 32'd2);
    dropAll();
    sample(); advance();

    // Store
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
    bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678;
    sample(); advance();
    sample();
    checkOutput("t4_ramWEN",   32'(bus.ramWEN), 32'd1);
    checkOutput("t4_ramREN",   32'(bus.ramREN), 32'd0);
    checkOutput("t4_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    checkOutput("t4_dload",    bus.dload, 32'd0);
    checkOutput("t4_dwait",    32'(bus.dwait), 32'd0);
    advance();
    dropAll();
    sample(); advance();

    // Timeout with RAM stuck BUSY, then successful retry
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 4) checkOutput("t5_last_mem_err", 32'(bus.mem_err), 32'd0);
      advance();
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    sample();
    checkOutput("t5_mem_err", 32'(bus.mem_err), 32'd1);
    checkOutput("t5_dwait",   32'(bus.dwait), 32'd1);
    checkOutput("t5_ramREN",  32'(bus.ramREN), 32'd0);
    advance();
    sample();
    checkOutput("t5_retry_dwait", 32'(bus.dwait), 32'd0);
    checkOutput("t5_retry_dload", bus.dload, 32'h77);
    advance();
    dropAll();
    sample(); advance();

    // Reset pulsed in the middle of a data grant
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
    sample(); advance();
    sample(); checkOutput("t6_pre_ramREN", 32'(bus.ramREN), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("t6_rst_ramREN",  32'(bus.ramREN), 32'd0);
    checkOutput("t6_rst_ramWEN",  32'(bus.ramWEN), 32'd0);
    checkOutput("t6_rst_mem_err", 32'(bus.mem_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    modelReset();
    #1;
    evalAndCheck();
    advance();
    sample(); checkOutput("t6_rearb_ramaddr", bus.ramaddr, 32'h400); advance();
    bus.ramstate = ACCESS;
    sample(); advance();
    dropAll();
    sample(); advance();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
